y86_mem_responder: RTL and testbench

Memory-side responder for the y86 sequential core's single-port bus. It holds a byte-addressable little-endian memory, returns unaligned 32-bit reads combinationally in the same cycle as `bus_RE`, and commits 32-bit writes on `bus_WE`. It also owns a byte-stream program-load port: the core is held in reset until the image is loaded, then released.

---
 rtl/y86_mem_responder.sv | 147 ++++++++++++++
 tb/tb_y86_mem_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_mem_responder.sv
// Byte-addressable memory responder for the y86 core bus, with a byte-stream image loader
// that holds the core in reset until loading completes. Define Y86_MEM_STATS_EN for access counters.
module y86_mem_responder #(
    parameter int AW = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_A,
    input  logic [31:0] bus_wdata,
    input  logic        bus_WE,
    input  logic        bus_RE,
    output logic [31:0] bus_rdata,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        cpu_rst,
    output logic        err,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] ld_ptr_reg, ld_ptr_next;
    logic          err_reg, err_next;
    logic          ld_ready_reg;
    logic          cpu_rst_reg;

    logic [7:0]    mem [0:DEPTH-1];
    logic [AW-1:0] byte_addr [0:3];
    logic [7:0]    rd_byte [0:3];

    logic          ld_accept;
    logic          run_write;
    logic          run_read;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^bus_A[31:AW];

    assign ld_accept = (state_reg == LOAD) && ld_valid && ld_ready_reg && !rst;
    assign run_write = (state_reg == RUN) && bus_WE && !rst;
    assign run_read  = (state_reg == RUN) && bus_RE;

    // Each lane addresses its own byte so unaligned and wrapping accesses fall out naturally.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_addr[gi] = bus_A[AW-1:0] + AW'(gi);
            assign rd_byte[gi]   = mem[byte_addr[gi]];
        end
    endgenerate

    assign bus_rdata = run_read ? {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]} : 32'd0;

    // Memory is deliberately left out of reset so a partial image survives a reload.
    always_ff @(posedge clk) begin
        if (ld_accept) begin
            mem[ld_ptr_reg] <= ld_data;
        end else if (run_write) begin
            for (int i = 0; i < 4; i++) begin
                mem[byte_addr[i]] <= bus_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        ld_ptr_next = ld_ptr_reg;
        err_next    = err_reg;
        case (state_reg)
            LOAD: begin
                if (bus_RE || bus_WE) begin
                    err_next = 1'b1;
                end
                if (ld_accept) begin
                    ld_ptr_next = ld_ptr_reg + AW'(1);
                    if (&ld_ptr_reg) begin
                        err_next = 1'b1;
                    end
                    if (ld_last) begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (bus_RE && bus_WE) begin
                    err_next = 1'b1;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // cpu_rst and ld_ready trail the state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= LOAD;
            ld_ptr_reg   <= '0;
            err_reg      <= 1'b0;
            ld_ready_reg <= 1'b1;
            cpu_rst_reg  <= 1'b1;
        end else begin
            state_reg    <= state_next;
            ld_ptr_reg   <= ld_ptr_next;
            err_reg      <= err_next;
            ld_ready_reg <= (state_reg == LOAD);
            cpu_rst_reg  <= (state_reg == LOAD);
        end
    end

    assign ld_ready = ld_ready_reg;
    assign cpu_rst  = cpu_rst_reg;
    assign err      = err_reg;

`ifdef Y86_MEM_STATS_EN
    logic [31:0] rd_count_reg;
    logic [31:0] wr_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_reg <= 32'd0;
            wr_count_reg <= 32'd0;
        end else begin
            if (run_read) begin
                rd_count_reg <= rd_count_reg + 32'd1;
            end
            if ((state_reg == RUN) && bus_WE) begin
                wr_count_reg <= wr_count_reg + 32'd1;
            end
        end
    end

    assign rd_count = rd_count_reg;
    assign wr_count = wr_count_reg;
`else
    assign rd_count = 32'd0;
    assign wr_count = 32'd0;
`endif

endmodule

// File: tb/tb_y86_mem_responder.sv
// Randomized bench for y86_mem_responder: a byte-array memory model checked every cycle,
// plus literal expectations for the load/read/write scenarios.
module tb_y86_mem_responder;
    localparam int AW  = 12;
    localparam int MSZ = 1 << AW;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bus_A;
    logic [31:0] bus_wdata;
    logic        bus_WE;
    logic        bus_RE;
    logic [31:0] bus_rdata;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        cpu_rst;
    logic        err;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    y86_mem_responder #(.AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_A     (bus_A),
        .bus_wdata (bus_wdata),
        .bus_WE    (bus_WE),
        .bus_RE    (bus_RE),
        .bus_rdata (bus_rdata),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .cpu_rst   (cpu_rst),
        .err       (err),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    // Reference model: plain byte array plus "loading" / "core held" flags.
    byte unsigned m_mem [MSZ];
    bit           m_valid   = 1'b0;
    bit           m_loading = 1'b1;
    bit           m_held    = 1'b1;
    bit           m_err     = 1'b0;
    int unsigned  m_ptr     = 0;
    int unsigned  m_rd      = 0;
    int unsigned  m_wr      = 0;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = m_mem[(a + i) & (MSZ - 1)];
        end
        return r;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_valid   = 1'b1;
            m_loading = 1'b1;
            m_held    = 1'b1;
            m_ptr     = 0;
            m_err     = 1'b0;
            m_rd      = 0;
            m_wr      = 0;
        end else if (m_valid) begin
            m_held = m_loading;
            if (m_loading) begin
                if (bus_RE || bus_WE) m_err = 1'b1;
                if (ld_valid) begin
                    m_mem[m_ptr] = ld_data;
                    if (m_ptr == MSZ - 1) m_err = 1'b1;
                    m_ptr = (m_ptr + 1) % MSZ;
                    if (ld_last) m_loading = 1'b0;
                end
            end else begin
                if (bus_RE && bus_WE) m_err = 1'b1;
                if (bus_RE) m_rd++;
                if (bus_WE) begin
                    m_wr++;
                    for (int i = 0; i < 4; i++) begin
                        m_mem[(bus_A + i) & (MSZ - 1)] = bus_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check32("bus_rdata", bus_rdata, (!m_loading && bus_RE) ? m_read(bus_A) : 32'd0);
            check32("cpu_rst", {31'd0, cpu_rst}, {31'd0, m_held});
            check32("ld_ready", {31'd0, ld_ready}, {31'd0, m_held});
            check32("err", {31'd0, err}, {31'd0, m_err});
`ifdef Y86_MEM_STATS_EN
            check32("rd_count", rd_count, m_rd);
            check32("wr_count", wr_count, m_wr);
`else
            check32("rd_count", rd_count, 32'd0);
            check32("wr_count", wr_count, 32'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic read_lit(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus_RE = 1'b1;
        bus_A  = a;
        @(negedge clk);
        check32(name, bus_rdata, exp);
        tick();
        bus_RE = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        bus_WE    = 1'b1;
        bus_A     = a;
        bus_wdata = d;
        tick();
        bus_WE = 1'b0;
    endtask

    task automatic random_bus(input int n);
        for (int k = 0; k < n; k++) begin
            bus_RE    = 1'($urandom_range(0, 1));
            bus_WE    = ($urandom_range(0, 3) == 0);
            bus_A     = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
            bus_wdata = $urandom;
            tick();
        end
        bus_RE = 1'b0;
        bus_WE = 1'b0;
    endtask

    initial begin
        logic [7:0] img [0:3];
        int n;
        img[0] = 8'h90; img[1] = 8'h01; img[2] = 8'hC3; img[3] = 8'hF4;
        rst = 1'b1; bus_A = 32'd0; bus_wdata = 32'd0; bus_WE = 1'b0; bus_RE = 1'b0;
        ld_valid = 1'b0; ld_data = 8'd0; ld_last = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        check32("reset_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check32("reset_rdata", bus_rdata, 32'd0);
        tick();

        // Zero the whole memory; the pointer wraps on the final byte.
        for (int i = 0; i < MSZ; i++) load_byte(8'h00, i == MSZ - 1);
        @(negedge clk);
        check32("wrap_err", {31'd0, err}, 32'd1);
        tick();
        do_reset();
        @(negedge clk);
        check32("err_cleared", {31'd0, err}, 32'd0);
        tick();

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check32("cpu_rst_load", {31'd0, cpu_rst}, 32'd1);
            tick();
            load_byte(img[i], i == 3);
        end
        @(negedge clk);
        check32("cpu_rst_after1", {31'd0, cpu_rst}, 32'd1);
        tick();
        @(negedge clk);
        check32("cpu_rst_after2", {31'd0, cpu_rst}, 32'd0);
        check32("ld_ready_after2", {31'd0, ld_ready}, 32'd0);
        tick();

        read_lit("rd_a0", 32'h0, 32'hF4C30190);
        read_lit("rd_a1", 32'h1, 32'h00F4C301);
        read_lit("rd_wrap", 32'hFFF, 32'hC3019000);

        write_word(32'h100, 32'hDEADBEEF);
        read_lit("rd_101", 32'h101, 32'h00DEADBE);
        read_lit("rd_100", 32'h100, 32'hDEADBEEF);

        write_word(32'h20, 32'h11223344);
        bus_RE = 1'b1; bus_WE = 1'b1; bus_A = 32'h20; bus_wdata = 32'h55667788;
        @(negedge clk);
        check32("rw_old_data", bus_rdata, 32'h11223344);
        tick();
        bus_RE = 1'b0; bus_WE = 1'b0;
        @(negedge clk);
        check32("rw_err", {31'd0, err}, 32'd1);
        tick();
        read_lit("rd_20_new", 32'h20, 32'h55667788);
        random_bus(3000);

        // Bus traffic during load, then reset part-way through an image.
        do_reset();
        bus_RE = 1'b1; bus_A = 32'h0;
        @(negedge clk);
        check32("load_rd_zero", bus_rdata, 32'd0);
        tick();
        bus_RE = 1'b0;
        write_word(32'h30, 32'hFFFFFFFF);
        @(negedge clk);
        check32("load_bus_err", {31'd0, err}, 32'd1);
        tick();
        load_byte(8'hAA, 1'b0);
        load_byte(8'hBB, 1'b0);
        do_reset();
        load_byte(8'hCC, 1'b0);
        load_byte(8'hDD, 1'b0);
        load_byte(8'hEE, 1'b0);
        load_byte(8'h99, 1'b1);
        repeat (2) tick();
        read_lit("reload_a0", 32'h0, 32'h99EEDDCC);
        random_bus(200);

        // Randomly gapped load stream.
        do_reset();
        n = 0;
        while (n < 20) begin
            ld_valid = ($urandom_range(0, 3) != 0);
            ld_data  = 8'($urandom);
            ld_last  = (n == 19);
            if (ld_valid) n++;
            tick();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        repeat (2) tick();
        random_bus(500);

        // Counter scenario: 3 reads and 2 writes in RUN.
        do_reset();
        load_byte(8'h7E, 1'b1);
        repeat (2) tick();
        for (int k = 0; k < 3; k++) begin
            bus_RE = 1'b1; bus_A = $urandom; tick();
        end
        bus_RE = 1'b0;
        for (int k = 0; k < 2; k++) write_word($urandom, $urandom);
        @(negedge clk);
`ifdef Y86_MEM_STATS_EN
        check32("rd_count_lit", rd_count, 32'd3);
        check32("wr_count_lit", wr_count, 32'd2);
`else
        check32("rd_count_lit", rd_count, 32'd0);
        check32("wr_count_lit", wr_count, 32'd0);
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
